dm_unit: RTL and testbench

//  Data-memory responder for the MEM stage: executes the MemWrite/DMOp requests the decoder issues for lw/lb/lh/sw/sb/sh.

---
 rtl/dm_unit_pkg.sv | 13 +
 rtl/dm_align.sv | 57 +++++
 rtl/dm_unit.sv | 74 +++++++
 tb/tb_dm_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_unit_pkg.sv
// Shared access-size codes for the decoder and the data-memory unit.
// Optional store trace is controlled by DM_TRACE_EN in dm_unit.
package dm_unit_pkg;
    localparam logic [1:0] DM_NONE     = 2'b00;
    localparam logic [1:0] DM_WORD     = 2'b01;
    localparam logic [1:0] DM_BYTE     = 2'b10;
    localparam logic [1:0] DM_HALFWORD = 2'b11;

    // Lane-level alignment rule. The range check lives in dm_unit because it depends on WORDS.
    function automatic logic misaligned(input logic [1:0] op, input logic [1:0] offset);
        return (op == DM_WORD && offset != 2'b00) || (op == DM_HALFWORD && offset[0]);
    endfunction
endpackage

// File: rtl/dm_align.sv
// Lane steering for the data memory: byte enables and replicated write data on the
// store side, lane selection and sign extension on the load side.
module dm_align
    import dm_unit_pkg::*;
(
    input  logic [1:0]  dm_op,
    input  logic [1:0]  offset,
    input  logic [31:0] wd,
    input  logic [31:0] raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] rd
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Store data is replicated into every lane; byte_en picks the lanes that commit.
    always_comb begin
        byte_en = 4'b0000;
        wdata   = wd;
        case (dm_op)
            DM_WORD: begin
                byte_en = 4'b1111;
                wdata   = wd;
            end
            DM_HALFWORD: begin
                byte_en = offset[1] ? 4'b1100 : 4'b0011;
                wdata   = {wd[15:0], wd[15:0]};
            end
            DM_BYTE: begin
                byte_en = 4'b0001 << offset;
                wdata   = {4{wd[7:0]}};
            end
            default: begin
                byte_en = 4'b0000;
                wdata   = wd;
            end
        endcase
    end

    always_comb begin
        sel_byte = raw[7:0];
        case (offset)
            2'd1:    sel_byte = raw[15:8];
            2'd2:    sel_byte = raw[23:16];
            2'd3:    sel_byte = raw[31:24];
            default: sel_byte = raw[7:0];
        endcase
        sel_half = offset[1] ? raw[31:16] : raw[15:0];
        case (dm_op)
            DM_WORD:     rd = raw;
            DM_HALFWORD: rd = {{16{sel_half[15]}}, sel_half};
            DM_BYTE:     rd = {{24{sel_byte[7]}}, sel_byte};
            default:     rd = 32'h0;
        endcase
    end
endmodule

// File: rtl/dm_unit.sv
// MEM-stage data memory: word RAM with byte-enable stores, zero-latency sign-extending loads
// and misalignment/range reporting. Define DM_TRACE_EN to print every committed store.
module dm_unit
    import dm_unit_pkg::*;
#(
    parameter int WORDS = 3072,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        MemWrite,
    input  logic [1:0]  DMOp,
    output logic [31:0] rd,
    output logic        align_err
);
    localparam logic [31:0] MEM_BYTES = 32'(4 * WORDS);

    logic [31:0]   mem [0:WORDS-1];
    logic [AW-1:0] idx;
    logic [3:0]    byte_en;
    logic [31:0]   wdata;
    logic [31:0]   load_rd;
    logic [31:0]   raw;
    logic          out_of_range;
    logic          store_en;

    assign idx          = addr[AW+1:2];
    // Full 32-bit compare so high address bits can never alias into the array.
    assign out_of_range = (DMOp != DM_NONE) && (addr >= MEM_BYTES);
    assign align_err    = misaligned(DMOp, addr[1:0]) || out_of_range;
    assign store_en     = MemWrite && (DMOp != DM_NONE) && !align_err;
    assign raw          = out_of_range ? 32'h0 : mem[idx];

    dm_align u_align (
        .dm_op   (DMOp),
        .offset  (addr[1:0]),
        .wd      (wd),
        .raw     (raw),
        .byte_en (byte_en),
        .wdata   (wdata),
        .rd      (load_rd)
    );

    assign rd = (reset || align_err || DMOp == DM_NONE) ? 32'h0 : load_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < WORDS; w++) mem[w] <= 32'h0;
        end else if (store_en) begin
            for (int l = 0; l < 4; l++) begin
                if (byte_en[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] new_word;
    logic [31:0] lane_mask;

    assign lane_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    assign new_word  = (raw & ~lane_mask) | (wdata & lane_mask);

    always_ff @(posedge clk) begin
        if (!reset && store_en)
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, new_word);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif
endmodule

// File: tb/tb_dm_unit.sv
// Self-checking bench for dm_unit: directed scenarios with fixed expectations plus a
// randomized run checked against a byte-addressed reference memory.
module tb_dm_unit;
    import dm_unit_pkg::*;

    localparam int WORDS = 3072;
    localparam int BYTES = 4 * WORDS;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        MemWrite;
    logic [1:0]  DMOp;
    logic [31:0] rd;
    logic        align_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  ref_b [0:BYTES-1];

    dm_unit #(.WORDS(WORDS), .AW(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .addr      (addr),
        .wd        (wd),
        .MemWrite  (MemWrite),
        .DMOp      (DMOp),
        .rd        (rd),
        .align_err (align_err)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Reference model: little-endian byte memory, sizes as byte counts.
    function automatic int op_bytes(input logic [1:0] op);
        case (op)
            DM_WORD:     return 4;
            DM_HALFWORD: return 2;
            DM_BYTE:     return 1;
            default:     return 0;
        endcase
    endfunction

    function automatic logic model_err(input logic [1:0] op, input logic [31:0] a);
        int n;
        n = op_bytes(op);
        if (n == 0) return 1'b0;
        if (a >= 32'(BYTES)) return 1'b1;
        return (n > 1) && ((a % n) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] op, input logic [31:0] a);
        longint v;
        int n;
        n = op_bytes(op);
        if (n == 0 || model_err(op, a)) return 32'h0;
        v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + ref_b[a + i];
        if (n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic model_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = op_bytes(op);
        if (n == 0 || model_err(op, a)) return;
        for (int i = 0; i < n; i++) ref_b[a + i] = d[8*i +: 8];
    endtask

    // Driver tasks
    task automatic set_bus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                           input logic we);
        DMOp = op; addr = a; wd = d; MemWrite = we;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        set_bus(op, a, d, 1'b1);
        tick();
        model_store(op, a, d);
        set_bus(DM_NONE, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_bus(DM_NONE, 32'h0, 32'h0, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < BYTES; i++) ref_b[i] = 8'h0;
        store(DM_WORD, 32'h0, 32'hDEADBEEF);
        set_bus(DM_WORD, 32'h0, 32'h0, 1'b0); #1;
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL reset_pre_write rd=%h exp=%h", rd, 32'hDEADBEEF);
        end
        // Reset wins over a simultaneous store.
        reset = 1'b1;
        set_bus(DM_WORD, 32'h0, 32'h11111111, 1'b1); #1;
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_rd_during rd=%h exp=0", rd); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < BYTES; i++) ref_b[i] = 8'h0;
        set_bus(DM_WORD, 32'h0, 32'h0, 1'b0); #1;
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_lw0 rd=%h exp=0", rd); end
        set_bus(DM_NONE, 32'h0, 32'h0, 1'b0); #1;
        checks++;
        if (align_err !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL reset_idle rd=%h err=%b exp rd=0 err=0", rd, align_err);
        end
    endtask

    task automatic test_word;
        set_bus(DM_WORD, 32'h10, 32'h12345678, 1'b1); #1;
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL word_same_cycle rd=%h exp=0", rd); end
        tick();
        model_store(DM_WORD, 32'h10, 32'h12345678);
        set_bus(DM_WORD, 32'h10, 32'h0, 1'b0); #1;
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL word_lw rd=%h exp=12345678", rd); end
    endtask

    task automatic test_bytes;
        logic [1:0]  op [3] = '{DM_BYTE, DM_BYTE, DM_WORD};
        logic [31:0] a  [3] = '{32'h21, 32'h22, 32'h20};
        logic [31:0] ex [3] = '{32'hFFFFFF80, 32'h0000007F, 32'h007F8000};
        store(DM_BYTE, 32'h21, 32'h00000080);
        store(DM_BYTE, 32'h22, 32'hFFFFFF7F);
        for (int i = 0; i < 3; i++) begin
            set_bus(op[i], a[i], 32'h0, 1'b0); #1;
            checks++;
            if (rd !== ex[i]) begin
                errors++; $display("FAIL bytes_%0d addr=%h rd=%h exp=%h", i, a[i], rd, ex[i]);
            end
        end
    endtask

    task automatic test_halfword;
        logic [1:0]  op [3] = '{DM_HALFWORD, DM_HALFWORD, DM_WORD};
        logic [31:0] a  [3] = '{32'h32, 32'h30, 32'h30};
        logic [31:0] ex [3] = '{32'hFFFF8001, 32'h00000000, 32'h80010000};
        store(DM_HALFWORD, 32'h32, 32'hABCD8001);
        for (int i = 0; i < 3; i++) begin
            set_bus(op[i], a[i], 32'h0, 1'b0); #1;
            checks++;
            if (rd !== ex[i]) begin
                errors++; $display("FAIL half_%0d addr=%h rd=%h exp=%h", i, a[i], rd, ex[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic [1:0]  op [5] = '{DM_WORD, DM_HALFWORD, DM_WORD, DM_BYTE, DM_HALFWORD};
        logic [31:0] a  [5] = '{32'h41, 32'h43, 32'h3000, 32'h2FFF, 32'h80000040};
        logic        ee [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            set_bus(op[i], a[i], 32'hFFFFFFFF, 1'b1); #1;
            checks++;
            if (align_err !== ee[i] || (ee[i] && rd !== 32'h0)) begin
                errors++;
                $display("FAIL err_%0d addr=%h err=%b rd=%h exp err=%b", i, a[i], align_err, rd, ee[i]);
            end
            tick();
            model_store(op[i], a[i], 32'hFFFFFFFF);
        end
        set_bus(DM_NONE, 32'h0, 32'h0, 1'b0);
        set_bus(DM_WORD, 32'h40, 32'h0, 1'b0); #1;
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL err_lw40 rd=%h exp=0", rd); end
        // Only the in-range byte store at the last byte commits.
        set_bus(DM_WORD, 32'h2FFC, 32'h0, 1'b0); #1;
        checks++;
        if (rd !== 32'hFF000000) begin errors++; $display("FAIL err_lastword rd=%h exp=ff000000", rd); end
        // MemWrite with no access size must not write.
        set_bus(DM_NONE, 32'h50, 32'hCAFEF00D, 1'b1); tick();
        set_bus(DM_WORD, 32'h50, 32'h0, 1'b0); #1;
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL none_write rd=%h exp=0", rd); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) store(DM_BYTE, 32'h60 + i, 32'(8'h11 * (i + 1)));
        store(DM_HALFWORD, 32'h66, 32'h0000BEEF);
        store(DM_BYTE, 32'h64, 32'h0000005A);
        set_bus(DM_WORD, 32'h60, 32'h0, 1'b0); #1;
        checks++;
        if (rd !== 32'h44332211) begin errors++; $display("FAIL b2b_w60 rd=%h exp=44332211", rd); end
        set_bus(DM_WORD, 32'h64, 32'h0, 1'b0); #1;
        checks++;
        if (rd !== 32'hBEEF005A) begin errors++; $display("FAIL b2b_w64 rd=%h exp=beef005a", rd); end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic [31:0] got;
        for (int n = 0; n < 400; n++) begin
            op = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            case ($urandom_range(0, 7))
                0:       a = 32'(BYTES - 4 + $urandom_range(0, 7));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, 127));
            endcase
            set_bus(op, a, d, we); #1;
            exp_q.push_back(model_load(op, a));
            got = exp_q.pop_front();
            checks++;
            if (rd !== got || align_err !== model_err(op, a)) begin
                errors++;
                $display("FAIL rand_%0d op=%0d addr=%h rd=%h err=%b exp rd=%h err=%b",
                         n, op, a, rd, align_err, got, model_err(op, a));
            end
            tick();
            if (we) model_store(op, a, d);
        end
        set_bus(DM_NONE, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        pc = 32'h3000;
        test_reset();
        test_word();
        test_bytes();
        test_halfword();
        test_errors();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
